// File: rtl/ds_ldst_sequencer.sv
// DS-form load/store sequencer: computes the EA, runs memory handshakes (two for stq) and emits GPR writebacks.
// Latency: accept C0, request C1, response C2 at the earliest, writeback C3; stall_o stays high from C1 until back in IDLE.
// Backpressure: the request is held stable until mem_req_ready_i; stall_o holds the decoder off; writebacks never stall.
module ds_ldst_sequencer #(
    parameter int regWidth     = 5,
    parameter int immWidth     = 14,
    parameter int dataWidth    = 64,
    parameter int addrWidth    = 64,
    parameter int LdStUnitCode = 2
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic                 enable_i,
    input  logic [2:0]           functionalUnitCode_i,
    input  logic [5:0]           opcode_i,
    input  logic [1:0]           xo_i,
    input  logic [regWidth-1:0]  reg1_i,
    input  logic [regWidth-1:0]  reg2_i,
    input  logic                 reg2ValOrZero_i,
    input  logic [immWidth-1:0]  imm_i,
    input  logic [dataWidth-1:0] ra_val_i,
    input  logic [dataWidth-1:0] rs_val_i,
    input  logic [dataWidth-1:0] rs1_val_i,
    output logic                 stall_o,
    output logic                 illegal_o,
    output logic                 mem_req_valid_o,
    input  logic                 mem_req_ready_i,
    output logic                 mem_req_we_o,
    output logic [1:0]           mem_req_size_o,
    output logic [addrWidth-1:0] mem_req_addr_o,
    output logic [dataWidth-1:0] mem_req_wdata_o,
    input  logic                 mem_rsp_valid_i,
    input  logic [dataWidth-1:0] mem_rsp_data_i,
    output logic                 wb_valid_o,
    output logic [regWidth-1:0]  wb_reg_o,
    output logic [dataWidth-1:0] wb_data_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_WAIT, S_REQ2, S_WAIT2, S_WB_RT, S_WB_RA
    } state_e;

    typedef enum logic [2:0] {
        OP_LD, OP_LDU, OP_LWA, OP_STD, OP_STDU, OP_STQ
    } op_e;

    state_e                 state_q;
    op_e                    op_q;
    logic [regWidth-1:0]    rt_q;
    logic [regWidth-1:0]    ra_q;
    logic [addrWidth-1:0]   ea_q;
    logic [dataWidth-1:0]   rs1_q;
    logic                   stall_q;
    logic                   illegal_q;
    logic                   req_valid_q;
    logic                   req_we_q;
    logic [1:0]             req_size_q;
    logic [addrWidth-1:0]   req_addr_q;
    logic [dataWidth-1:0]   req_wdata_q;
    logic                   wb_valid_q;
    logic [regWidth-1:0]    wb_reg_q;
    logic [dataWidth-1:0]   wb_data_q;

    op_e                    op_d;
    logic                   dec_legal;
    logic                   dec_illegal;
    logic                   accept;
    logic [addrWidth-1:0]   base;
    logic [addrWidth-1:0]   ea_d;
    logic [dataWidth-1:0]   lwa_ext;

    assign accept  = enable_i && (functionalUnitCode_i == 3'(LdStUnitCode)) && (state_q == S_IDLE);
    assign base    = (reg2ValOrZero_i && (reg2_i == '0)) ? '0 : addrWidth'(ra_val_i);
    assign ea_d    = base + {{(addrWidth-immWidth-2){imm_i[immWidth-1]}}, imm_i, 2'b00};
    assign lwa_ext = {{(dataWidth-32){mem_rsp_data_i[31]}}, mem_rsp_data_i[31:0]};

    always_comb begin
        op_d        = OP_LD;
        dec_legal   = 1'b0;
        dec_illegal = 1'b0;
        if (opcode_i == 6'd58 || opcode_i == 6'd62) begin
            case (xo_i)
                2'd0:    op_d = (opcode_i == 6'd58) ? OP_LD  : OP_STD;
                2'd1:    op_d = (opcode_i == 6'd58) ? OP_LDU : OP_STDU;
                2'd2:    op_d = (opcode_i == 6'd58) ? OP_LWA : OP_STQ;
                default: dec_illegal = 1'b1;
            endcase
            if (op_d == OP_LDU && (reg2_i == '0 || reg2_i == reg1_i))
                dec_illegal = 1'b1;
            if (op_d == OP_STDU && reg2_i == '0)
                dec_illegal = 1'b1;
            // quadword stores need an even/odd register pair
            if (op_d == OP_STQ && reg1_i[0])
                dec_illegal = 1'b1;
            dec_legal = !dec_illegal;
        end
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q     <= S_IDLE;
            op_q        <= OP_LD;
            rt_q        <= '0;
            ra_q        <= '0;
            ea_q        <= '0;
            rs1_q       <= '0;
            stall_q     <= 1'b0;
            illegal_q   <= 1'b0;
            req_valid_q <= 1'b0;
            req_we_q    <= 1'b0;
            req_size_q  <= '0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            wb_valid_q  <= 1'b0;
            wb_reg_q    <= '0;
            wb_data_q   <= '0;
        end else begin
            illegal_q  <= 1'b0;
            wb_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept && dec_illegal) begin
                        illegal_q <= 1'b1;
                    end else if (accept && dec_legal) begin
                        op_q        <= op_d;
                        rt_q        <= reg1_i;
                        ra_q        <= reg2_i;
                        ea_q        <= ea_d;
                        rs1_q       <= rs1_val_i;
                        req_valid_q <= 1'b1;
                        req_we_q    <= (op_d == OP_STD || op_d == OP_STDU || op_d == OP_STQ);
                        req_size_q  <= (op_d == OP_LWA) ? 2'd2 : 2'd3;
                        req_addr_q  <= ea_d;
                        req_wdata_q <= rs_val_i;
                        stall_q     <= 1'b1;
                        state_q     <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (mem_req_ready_i) begin
                        req_valid_q <= 1'b0;
                        state_q     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_rsp_valid_i) begin
                        case (op_q)
                            OP_LD, OP_LDU, OP_LWA: begin
                                wb_valid_q <= 1'b1;
                                wb_reg_q   <= rt_q;
                                wb_data_q  <= (op_q == OP_LWA) ? lwa_ext : mem_rsp_data_i;
                                state_q    <= S_WB_RT;
                            end
                            OP_STDU: begin
                                wb_valid_q <= 1'b1;
                                wb_reg_q   <= ra_q;
                                wb_data_q  <= dataWidth'(ea_q);
                                state_q    <= S_WB_RA;
                            end
                            OP_STQ: begin
                                req_valid_q <= 1'b1;
                                req_addr_q  <= ea_q + addrWidth'(8);
                                req_wdata_q <= rs1_q;
                                state_q     <= S_REQ2;
                            end
                            default: begin
                                stall_q <= 1'b0;
                                state_q <= S_IDLE;
                            end
                        endcase
                    end
                end
                S_REQ2: begin
                    if (mem_req_ready_i) begin
                        req_valid_q <= 1'b0;
                        state_q     <= S_WAIT2;
                    end
                end
                S_WAIT2: begin
                    if (mem_rsp_valid_i) begin
                        stall_q <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                S_WB_RT: begin
                    if (op_q == OP_LDU) begin
                        wb_valid_q <= 1'b1;
                        wb_reg_q   <= ra_q;
                        wb_data_q  <= dataWidth'(ea_q);
                        state_q    <= S_WB_RA;
                    end else begin
                        stall_q <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    stall_q <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign stall_o         = stall_q;
    assign illegal_o       = illegal_q;
    assign mem_req_valid_o = req_valid_q;
    assign mem_req_we_o    = req_we_q;
    assign mem_req_size_o  = req_size_q;
    assign mem_req_addr_o  = req_addr_q;
    assign mem_req_wdata_o = req_wdata_q;
    assign wb_valid_o      = wb_valid_q;
    assign wb_reg_o        = wb_reg_q;
    assign wb_data_o       = wb_data_q;

endmodule

// File: tb/tb_ds_ldst_sequencer.sv
// Bench for ds_ldst_sequencer: vector table plus hand-written latency, stall and reset sequences.
module tb_ds_ldst_sequencer;

    logic        clock_i = 1'b0;
    logic        reset_i = 1'b0;
    logic        enable_i = 1'b0;
    logic [2:0]  functionalUnitCode_i = '0;
    logic [5:0]  opcode_i = '0;
    logic [1:0]  xo_i = '0;
    logic [4:0]  reg1_i = '0;
    logic [4:0]  reg2_i = '0;
    logic        reg2ValOrZero_i = 1'b0;
    logic [13:0] imm_i = '0;
    logic [63:0] ra_val_i = '0;
    logic [63:0] rs_val_i = '0;
    logic [63:0] rs1_val_i = '0;
    logic        stall_o, illegal_o, mem_req_valid_o, mem_req_we_o;
    logic        mem_req_ready_i = 1'b0;
    logic [1:0]  mem_req_size_o;
    logic [63:0] mem_req_addr_o, mem_req_wdata_o;
    logic        mem_rsp_valid_i = 1'b0;
    logic [63:0] mem_rsp_data_i = '0;
    logic        wb_valid_o;
    logic [4:0]  wb_reg_o;
    logic [63:0] wb_data_o;

    ds_ldst_sequencer dut (
        .clock_i(clock_i), .reset_i(reset_i), .enable_i(enable_i),
        .functionalUnitCode_i(functionalUnitCode_i), .opcode_i(opcode_i), .xo_i(xo_i),
        .reg1_i(reg1_i), .reg2_i(reg2_i), .reg2ValOrZero_i(reg2ValOrZero_i), .imm_i(imm_i),
        .ra_val_i(ra_val_i), .rs_val_i(rs_val_i), .rs1_val_i(rs1_val_i),
        .stall_o(stall_o), .illegal_o(illegal_o),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_req_we_o(mem_req_we_o), .mem_req_size_o(mem_req_size_o),
        .mem_req_addr_o(mem_req_addr_o), .mem_req_wdata_o(mem_req_wdata_o),
        .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_data_i(mem_rsp_data_i),
        .wb_valid_o(wb_valid_o), .wb_reg_o(wb_reg_o), .wb_data_o(wb_data_o)
    );

    always #5 clock_i = ~clock_i;

    typedef struct {
        logic [2:0]  unit;  logic [5:0]  opc;  logic [1:0]  xo;
        logic [4:0]  r1;    logic [4:0]  r2;   logic        rz;   logic [13:0] imm;
        logic [63:0] ra;    logic [63:0] rs;   logic [63:0] rs1;  logic [63:0] rsp;
        int          dly;   logic        ill;  logic        stl;
        int          nreq;  logic [63:0] a0;   logic [1:0]  sz;
        int          nwb;   logic [4:0]  w0r;  logic [63:0] w0d;  logic [4:0] w1r; logic [63:0] w1d;
    } vec_t;

    typedef struct { logic [63:0] addr; logic we; logic [1:0] size; logic [63:0] wdata; } req_t;
    typedef struct { logic [4:0] r; logic [63:0] d; } wb_t;

    req_t exp_req[$];
    wb_t  exp_wb[$];
    vec_t tbl[$];

    int          nchecks = 0;
    int          nerrors = 0;
    int          rdy_delay = 0;
    logic [63:0] cur_rsp = '0;
    logic        rsp_block = 1'b0;
    logic        hs = 1'b0;
    int          wcnt = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(logic [2:0] unit, logic [5:0] opc, logic [1:0] xo, logic [4:0] r1,
                                logic [4:0] r2, logic rz, logic [13:0] imm, logic [63:0] ra,
                                logic [63:0] rs, logic [63:0] rs1, logic [63:0] rsp, int dly,
                                logic ill, logic stl, int nreq, logic [63:0] a0, logic [1:0] sz,
                                int nwb, logic [4:0] w0r, logic [63:0] w0d, logic [4:0] w1r,
                                logic [63:0] w1d);
        vec_t t;
        t.unit = unit; t.opc = opc; t.xo = xo; t.r1 = r1; t.r2 = r2; t.rz = rz; t.imm = imm;
        t.ra = ra; t.rs = rs; t.rs1 = rs1; t.rsp = rsp; t.dly = dly; t.ill = ill; t.stl = stl;
        t.nreq = nreq; t.a0 = a0; t.sz = sz; t.nwb = nwb;
        t.w0r = w0r; t.w0d = w0d; t.w1r = w1r; t.w1d = w1d;
        return t;
    endfunction

    // Memory model: ready after rdy_delay cycles of valid, response the cycle after the handshake.
    initial begin
        forever begin
            @(negedge clock_i);
            if (mem_req_valid_o && mem_req_ready_i) hs = 1'b1;
            @(posedge clock_i);
            #1;
            mem_rsp_valid_i = hs && !rsp_block;
            mem_rsp_data_i  = cur_rsp;
            hs = 1'b0;
            if (mem_req_valid_o) begin
                if (wcnt >= rdy_delay) mem_req_ready_i = 1'b1;
                else begin mem_req_ready_i = 1'b0; wcnt++; end
            end else begin
                mem_req_ready_i = 1'b0;
                wcnt = 0;
            end
        end
    end

    // Scoreboard: every valid request cycle must match the head entry; writebacks pop in order.
    always @(negedge clock_i) begin
        if (reset_i) begin
            if (mem_req_valid_o) begin
                if (exp_req.size() == 0) begin
                    nchecks++; nerrors++;
                    $display("FAIL unexpected_req: got addr %h expected none", mem_req_addr_o);
                end else begin
                    chk("req_addr", mem_req_addr_o, exp_req[0].addr);
                    chk("req_we_size", {61'd0, mem_req_we_o, mem_req_size_o},
                        {61'd0, exp_req[0].we, exp_req[0].size});
                    if (exp_req[0].we) chk("req_wdata", mem_req_wdata_o, exp_req[0].wdata);
                    if (mem_req_ready_i) void'(exp_req.pop_front());
                end
            end
            if (wb_valid_o) begin
                if (exp_wb.size() == 0) begin
                    nchecks++; nerrors++;
                    $display("FAIL unexpected_wb: got r%0d=%h expected none", wb_reg_o, wb_data_o);
                end else begin
                    chk("wb_reg", 64'(wb_reg_o), 64'(exp_wb[0].r));
                    chk("wb_data", wb_data_o, exp_wb[0].d);
                    void'(exp_wb.pop_front());
                end
            end
        end
    end

    task automatic issue(input vec_t t, input logic push_wb);
        req_t r;
        wb_t  w;
        for (int i = 0; i < t.nreq; i++) begin
            r.addr = t.a0 + 64'(8 * i); r.we = (t.opc == 6'd62); r.size = t.sz;
            r.wdata = (i == 0) ? t.rs : t.rs1;
            exp_req.push_back(r);
        end
        if (push_wb && t.nwb > 0) begin w.r = t.w0r; w.d = t.w0d; exp_wb.push_back(w); end
        if (push_wb && t.nwb > 1) begin w.r = t.w1r; w.d = t.w1d; exp_wb.push_back(w); end
        cur_rsp = t.rsp; rdy_delay = t.dly;
        @(posedge clock_i); #1;
        enable_i = 1'b1; functionalUnitCode_i = t.unit; opcode_i = t.opc; xo_i = t.xo;
        reg1_i = t.r1; reg2_i = t.r2; reg2ValOrZero_i = t.rz; imm_i = t.imm;
        ra_val_i = t.ra; rs_val_i = t.rs; rs1_val_i = t.rs1;
        @(posedge clock_i); #1;
        enable_i = 1'b0;
        chk("illegal", 64'(illegal_o), 64'(t.ill));
        chk("stall_after_accept", 64'(stall_o), 64'(t.stl));
    endtask

    task automatic wait_idle();
        int n = 0;
        while (stall_o && n < 60) begin @(negedge clock_i); n++; end
        if (stall_o) begin
            nchecks++; nerrors++;
            $display("FAIL idle_timeout: got stall_o=1 expected 0 within 60 cycles");
        end
        repeat (2) @(posedge clock_i);
        #1;
        chk("req_queue_drained", 64'(exp_req.size()), 64'd0);
        chk("wb_queue_drained", 64'(exp_wb.size()), 64'd0);
    endtask

    initial begin
        vec_t t;
        logic exp_st[4];
        logic exp_wv[4];
        exp_st[0] = 1; exp_st[1] = 1; exp_st[2] = 1; exp_st[3] = 0;
        exp_wv[0] = 0; exp_wv[1] = 0; exp_wv[2] = 1; exp_wv[3] = 0;

        //            unit opc xo r1 r2 rz imm       ra                      rs          rs1         rsp                     dly ill stl nreq a0                      sz nwb w0r w0d                     w1r w1d
        tbl.push_back(mk(2, 58, 0, 3, 4, 0, 14'h0010, 64'h1000,              64'h0,      64'h0,      64'h0123456789ABCDEF, 0, 0, 1, 1, 64'h1040,              3, 1, 3, 64'h0123456789ABCDEF, 0, 0));
        tbl.push_back(mk(2, 58, 2, 7, 0, 1, 14'h3FFF, 64'hDEAD,              64'h0,      64'h0,      64'h1234567880000001, 1, 0, 1, 1, 64'hFFFFFFFFFFFFFFFC,  2, 1, 7, 64'hFFFFFFFF80000001, 0, 0));
        tbl.push_back(mk(2, 58, 1, 5, 6, 0, 14'h0002, 64'h2000,              64'h0,      64'h0,      64'hAAAA555500001234, 0, 0, 1, 1, 64'h2008,              3, 2, 5, 64'hAAAA555500001234, 6, 64'h2008));
        tbl.push_back(mk(2, 58, 1, 5, 5, 0, 14'h0002, 64'h2000,              64'h0,      64'h0,      64'h0,                0, 1, 0, 0, 64'h0,                 3, 0, 0, 64'h0,                0, 0));
        tbl.push_back(mk(2, 62, 2, 8, 1, 0, 14'h0000, 64'h100,               64'h1111,   64'h2222,   64'h0,                3, 0, 1, 2, 64'h100,               3, 0, 0, 64'h0,                0, 0));
        tbl.push_back(mk(2, 62, 2, 9, 1, 0, 14'h0000, 64'h100,               64'h1111,   64'h2222,   64'h0,                0, 1, 0, 0, 64'h0,                 3, 0, 0, 64'h0,                0, 0));
        tbl.push_back(mk(2, 62, 1, 10, 2, 0, 14'h3FFE, 64'h10,               64'h5555,   64'h0,      64'h0,                0, 0, 1, 1, 64'h8,                 3, 1, 2, 64'h8,                0, 0));
        tbl.push_back(mk(2, 58, 3, 3, 4, 0, 14'h0010, 64'h1000,              64'h0,      64'h0,      64'h0,                0, 1, 0, 0, 64'h0,                 3, 0, 0, 64'h0,                0, 0));
        tbl.push_back(mk(2, 58, 1, 5, 0, 1, 14'h0004, 64'h0,                 64'h0,      64'h0,      64'h0,                0, 1, 0, 0, 64'h0,                 3, 0, 0, 64'h0,                0, 0));
        tbl.push_back(mk(2, 62, 1, 4, 0, 1, 14'h0004, 64'h0,                 64'h0,      64'h0,      64'h0,                0, 1, 0, 0, 64'h0,                 3, 0, 0, 64'h0,                0, 0));
        tbl.push_back(mk(2, 62, 0, 4, 0, 0, 14'h0001, 64'h7,                 64'hCAFE,   64'h0,      64'h0,                2, 0, 1, 1, 64'hB,                 3, 0, 0, 64'h0,                0, 0));
        tbl.push_back(mk(2, 58, 0, 1, 2, 0, 14'h0004, 64'hFFFFFFFFFFFFFFF8,  64'h0,      64'h0,      64'h77,               0, 0, 1, 1, 64'h8,                 3, 1, 1, 64'h77,               0, 0));
        tbl.push_back(mk(1, 58, 0, 3, 4, 0, 14'h0010, 64'h1000,              64'h0,      64'h0,      64'h0,                0, 0, 0, 0, 64'h0,                 3, 0, 0, 64'h0,                0, 0));
        tbl.push_back(mk(2, 58, 2, 11, 3, 0, 14'h0001, 64'h40,               64'h0,      64'h0,      64'hFFFFFFFF7FFFFFFF, 0, 0, 1, 1, 64'h44,                2, 1, 11, 64'h000000007FFFFFFF, 0, 0));

        repeat (3) @(posedge clock_i);
        #1;
        chk("rst_stall", 64'(stall_o), 64'd0);
        chk("rst_illegal", 64'(illegal_o), 64'd0);
        chk("rst_req_valid", 64'(mem_req_valid_o), 64'd0);
        chk("rst_req_we", 64'(mem_req_we_o), 64'd0);
        chk("rst_wb_valid", 64'(wb_valid_o), 64'd0);
        chk("rst_req_addr", mem_req_addr_o, 64'd0);
        chk("rst_wb_data", wb_data_o, 64'd0);
        reset_i = 1'b1;

        foreach (tbl[i]) begin
            issue(tbl[i], 1'b1);
            wait_idle();
        end

        // Minimum-latency load: stall over C1..C3, writeback in C3.
        issue(tbl[0], 1'b1);
        chk("lat_req_valid_c1", 64'(mem_req_valid_o), 64'd1);
        for (int k = 0; k < 4; k++) begin
            chk("lat_stall", 64'(stall_o), 64'(exp_st[k]));
            chk("lat_wb_valid", 64'(wb_valid_o), 64'(exp_wv[k]));
            @(posedge clock_i); #1;
        end
        wait_idle();

        // A second op presented while busy must be ignored.
        issue(tbl[6], 1'b1);
        enable_i = 1'b1; opcode_i = 6'd62; xo_i = 2'd0; reg1_i = 5'd4; reg2_i = 5'd3;
        imm_i = 14'h0100; ra_val_i = 64'h9000; rs_val_i = 64'hBAD;
        repeat (2) @(posedge clock_i);
        #1;
        enable_i = 1'b0;
        wait_idle();

        // Reset while a load waits for its response: drop it, no writeback.
        rsp_block = 1'b1;
        issue(tbl[0], 1'b0);
        repeat (3) @(posedge clock_i);
        #3;
        chk("mid_stall_before_reset", 64'(stall_o), 64'd1);
        reset_i = 1'b0;
        #1;
        chk("mid_rst_stall", 64'(stall_o), 64'd0);
        chk("mid_rst_req_valid", 64'(mem_req_valid_o), 64'd0);
        chk("mid_rst_req_addr", mem_req_addr_o, 64'd0);
        chk("mid_rst_wb_valid", 64'(wb_valid_o), 64'd0);
        chk("mid_rst_req_q", 64'(exp_req.size()), 64'd0);
        rsp_block = 1'b0;
        repeat (2) @(posedge clock_i);
        #3;
        reset_i = 1'b1;
        repeat (2) @(posedge clock_i);
        #1;
        chk("post_rst_no_wb", 64'(wb_valid_o), 64'd0);
        issue(tbl[0], 1'b1);
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
